// File: rtl/hs_arith_merge_pkg.sv
// Shared types for the K-way unsigned-minimum merge stage.
// The head-register payload struct depends on the AUX_DATA_TYPE type
// parameter, so it is declared inside the merge module itself; only the
// parameter-independent pieces live here.
package hs_arith_merge_pkg;

  typedef enum logic {
    BOOL_FALSE = 1'b0,
    BOOL_TRUE  = 1'b1
  } bool_e;

  // Per-lane sequencing bits: lane_done latches after the lane's last beat
  // is accepted; head_valid marks an occupied head register.
  typedef struct packed {
    logic lane_done;
    logic head_valid;
  } lane_state_t;

endpackage

// File: rtl/hs_arith_multi_in_uminimize.sv
// Combinational multi-input unsigned minimizer.
// Returns the smallest valid key, its lane index and (optionally) its aux
// payload. Equal keys resolve to the lowest lane index.
module hs_arith_multi_in_uminimize
  import hs_arith_merge_pkg::*;
#(
  parameter int    DATA_WIDTH      = 32,
  parameter int    INPUT_NUM       = 4,
  parameter bool_e ENABLE_AUX_PATH = BOOL_TRUE,
  parameter type   AUX_DATA_TYPE   = logic,
  localparam int   INDEX_WIDTH     = $clog2(INPUT_NUM)
) (
  input  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0] din,
  input  logic [INPUT_NUM-1:0]                 valid,
  input  AUX_DATA_TYPE [INPUT_NUM-1:0]         aux,
  output logic [DATA_WIDTH-1:0]                min_data,
  output logic [INDEX_WIDTH-1:0]               min_index,
  output AUX_DATA_TYPE                         min_aux,
  output logic                                 min_valid
);

  // Linear scan; a strict less-than keeps the earlier (lower) lane on ties.
  always_comb begin
    min_valid = 1'b0;
    min_data  = '0;
    min_index = '0;
    min_aux   = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (valid[i] && (!min_valid || (din[i] < min_data))) begin
        min_valid = 1'b1;
        min_data  = din[i];
        min_index = INDEX_WIDTH'(i);
        if (ENABLE_AUX_PATH == BOOL_TRUE) begin
          min_aux = aux[i];
        end
      end
    end
  end

endmodule

// File: rtl/hs_arith_multi_in_umin_merge.sv
// Sequential K-way merge: one head register per lane, the smallest head is
// emitted through a registered output beat with its lane index and aux.
//
// Handshake semantics (all ports): a beat transfers on a rising clock edge
// where valid & ready are both 1. A producer holding valid may change its
// payload only after the transfer; out_* stay stable while
// out_valid & ~out_ready. in_ready is combinational and may depend on
// out_ready through the same-cycle pop.
module hs_arith_multi_in_umin_merge
  import hs_arith_merge_pkg::*;
#(
  parameter int    DATA_WIDTH    = 32,
  parameter int    INPUT_NUM     = 4,
  parameter type   AUX_DATA_TYPE = logic,
  parameter bool_e STRICT_ORDER  = BOOL_TRUE,
  localparam int   INDEX_WIDTH   = $clog2(INPUT_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [INPUT_NUM-1:0]                 lane_enable,
  input  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0] in_data,
  input  AUX_DATA_TYPE [INPUT_NUM-1:0]         in_aux,
  input  logic [INPUT_NUM-1:0]                 in_last,
  input  logic [INPUT_NUM-1:0]                 in_valid,
  output logic [INPUT_NUM-1:0]                 in_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output AUX_DATA_TYPE                         out_aux,
  output logic [INDEX_WIDTH-1:0]               out_index,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    AUX_DATA_TYPE          aux;
    logic                  last;
  } head_t;

  // Payload routed through the minimizer alongside the key.
  typedef struct packed {
    AUX_DATA_TYPE aux;
    logic         last;
  } min_aux_t;

  head_t       head    [INPUT_NUM];
  lane_state_t lane_st [INPUT_NUM];

  logic [INPUT_NUM-1:0]                 head_valid;
  logic [INPUT_NUM-1:0]                 lane_done;
  logic [INPUT_NUM-1:0]                 resolved;
  logic [INPUT_NUM-1:0]                 pop;
  logic [INPUT_NUM-1:0]                 accept;
  logic [INPUT_NUM-1:0]                 heads_after;
  logic [INPUT_NUM-1:0]                 done_after;
  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0] min_din;
  min_aux_t [INPUT_NUM-1:0]             min_aux_in;

  logic [DATA_WIDTH-1:0]  min_data;
  logic [INDEX_WIDTH-1:0] min_index;
  min_aux_t               min_aux;
  logic                   min_valid;

  logic sel_ok;
  logic fire;
  logic rearm;
  logic next_last;

  hs_arith_multi_in_uminimize #(
    .DATA_WIDTH      (DATA_WIDTH),
    .INPUT_NUM       (INPUT_NUM),
    .ENABLE_AUX_PATH (BOOL_TRUE),
    .AUX_DATA_TYPE   (min_aux_t)
  ) u_umin (
    .din       (min_din),
    .valid     (head_valid),
    .aux       (min_aux_in),
    .min_data  (min_data),
    .min_index (min_index),
    .min_aux   (min_aux),
    .min_valid (min_valid)
  );

  // Selection, pop and refill decisions for the current cycle.
  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      head_valid[i]      = lane_st[i].head_valid;
      lane_done[i]       = lane_st[i].lane_done;
      min_din[i]         = head[i].data;
      min_aux_in[i].aux  = head[i].aux;
      min_aux_in[i].last = head[i].last;
    end
    // A lane is resolved when it cannot still deliver a smaller key later.
    resolved = ~lane_enable | head_valid | lane_done;
    sel_ok   = min_valid & ((STRICT_ORDER == BOOL_TRUE) ? (&resolved) : 1'b1);
    fire     = sel_ok & (~out_valid | out_ready);
    for (int i = 0; i < INPUT_NUM; i++) begin
      pop[i] = fire & (min_index == INDEX_WIDTH'(i));
    end
    in_ready    = lane_enable & ~lane_done & (~head_valid | pop);
    accept      = in_valid & in_ready;
    heads_after = (head_valid & ~pop) | accept;
    done_after  = lane_done | (accept & in_last);
    // Frame ends when the popped beat is its lane's final beat, nothing is
    // left in any head and every enabled lane has finished.
    next_last   = min_aux.last & ~(|heads_after) & (&(done_after | ~lane_enable));
    rearm       = out_valid & out_ready & out_last;
    busy        = (|head_valid) | out_valid | (|lane_done);
  end

  // Head registers and per-lane done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        head[i]    <= '0;
        lane_st[i] <= '0;
      end
    end else begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (accept[i]) begin
          head[i].data          <= in_data[i];
          head[i].aux           <= in_aux[i];
          head[i].last          <= in_last[i];
          lane_st[i].head_valid <= 1'b1;
        end else if (pop[i]) begin
          lane_st[i].head_valid <= 1'b0;
        end
        if (rearm) begin
          lane_st[i].lane_done <= 1'b0;
        end else if (accept[i] && in_last[i]) begin
          lane_st[i].lane_done <= 1'b1;
        end
      end
    end
  end

  // Registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_aux   <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= min_data;
      out_aux   <= min_aux.aux;
      out_index <= min_index;
      out_last  <= next_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs_arith_multi_in_umin_merge.sv
// Bench for the K-way merge stage: a strict-order and a greedy instance share
// the lane inputs; the idle one is held with lane_enable=0. Expected beats
// come from sorting each frame's beats by (key, lane, position).
module tb_hs_arith_multi_in_umin_merge;
  import hs_arith_merge_pkg::*;

  localparam int W     = 32;
  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int IW    = 2;
  localparam int EXP_W = 1 + IW + AW + W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic [N-1:0][W-1:0]  in_data;
  logic [N-1:0][AW-1:0] in_aux;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_valid;
  logic                 out_ready;
  logic [N-1:0]         en_s, en_g;
  bit                   sel;

  logic [N-1:0]  s_in_ready, g_in_ready;
  logic [W-1:0]  s_out_data, g_out_data;
  logic [AW-1:0] s_out_aux, g_out_aux;
  logic [IW-1:0] s_out_index, g_out_index;
  logic          s_out_last, g_out_last, s_out_valid, g_out_valid, s_busy, g_busy;

  hs_arith_multi_in_umin_merge #(
    .DATA_WIDTH(W), .INPUT_NUM(N), .AUX_DATA_TYPE(logic [AW-1:0]), .STRICT_ORDER(BOOL_TRUE)
  ) u_dut_strict (
    .clk(clk), .rst_n(rst_n), .lane_enable(en_s), .in_data(in_data), .in_aux(in_aux),
    .in_last(in_last), .in_valid(in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_aux(s_out_aux), .out_index(s_out_index), .out_last(s_out_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .busy(s_busy)
  );

  hs_arith_multi_in_umin_merge #(
    .DATA_WIDTH(W), .INPUT_NUM(N), .AUX_DATA_TYPE(logic [AW-1:0]), .STRICT_ORDER(BOOL_FALSE)
  ) u_dut_greedy (
    .clk(clk), .rst_n(rst_n), .lane_enable(en_g), .in_data(in_data), .in_aux(in_aux),
    .in_last(in_last), .in_valid(in_valid), .in_ready(g_in_ready), .out_data(g_out_data),
    .out_aux(g_out_aux), .out_index(g_out_index), .out_last(g_out_last),
    .out_valid(g_out_valid), .out_ready(out_ready), .busy(g_busy)
  );

  logic [N-1:0]     obs_in_ready;
  logic [W-1:0]     obs_out_data;
  logic [AW-1:0]    obs_out_aux;
  logic [IW-1:0]    obs_out_index;
  logic             obs_out_last, obs_out_valid, obs_busy;
  logic [EXP_W-1:0] obs_word;
  assign obs_in_ready  = sel ? g_in_ready  : s_in_ready;
  assign obs_out_data  = sel ? g_out_data  : s_out_data;
  assign obs_out_aux   = sel ? g_out_aux   : s_out_aux;
  assign obs_out_index = sel ? g_out_index : s_out_index;
  assign obs_out_last  = sel ? g_out_last  : s_out_last;
  assign obs_out_valid = sel ? g_out_valid : s_out_valid;
  assign obs_busy      = sel ? g_busy      : s_busy;
  assign obs_word      = {obs_out_last, obs_out_index, obs_out_aux, obs_out_data};

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [EXP_W-1:0] exp_q[$];
  int hs_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame description ----------------
  bit         f_greedy;
  logic [N-1:0] f_en;
  int         f_len   [N];
  logic [W-1:0] f_key [N][8];
  logic [AW-1:0] f_aux [N][8];
  int         f_delay [N];
  int         valid_pct, ready_pct, bp_start, stall_lane;

  task automatic frame_defaults();
    f_greedy   = 0;
    f_en       = 4'hF;
    valid_pct  = 100;
    ready_pct  = 100;
    bp_start   = -1;
    stall_lane = -1;
    for (int i = 0; i < N; i++) begin
      f_len[i]   = 0;
      f_delay[i] = 0;
      for (int p = 0; p < 8; p++) f_aux[i][p] = AW'($urandom);
    end
  endtask

  task automatic gen_lanes(input int maxlen);
    int k;
    for (int i = 0; i < N; i++) begin
      f_len[i] = f_en[i] ? int'($urandom_range(1, maxlen)) : 0;
      k = int'($urandom_range(0, 30));
      for (int p = 0; p < 8; p++) begin
        f_key[i][p] = W'(k);
        k = k + int'($urandom_range(0, 12));
      end
    end
  endtask

  // Reference: the merged frame is every beat ordered by key, ties by lane
  // then by position in the lane; only the final beat carries last.
  task automatic push_expected();
    logic [63:0] ent[$];
    logic [63:0] e;
    for (int l = 0; l < N; l++) begin
      for (int p = 0; p < f_len[l]; p++) begin
        e        = '0;
        e[44:13] = f_key[l][p];
        e[12:11] = IW'(l);
        e[10:8]  = 3'(p);
        e[7:0]   = f_aux[l][p];
        ent.push_back(e);
      end
    end
    ent.sort();
    for (int k = 0; k < ent.size(); k++) begin
      e = ent[k];
      exp_q.push_back({(k == ent.size() - 1), e[12:11], e[7:0], e[44:13]});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame();
    int  ptr[N];
    bit  done;
    for (int i = 0; i < N; i++) ptr[i] = 0;
    sel = f_greedy;
    if (f_greedy) begin en_g = f_en; en_s = '0; end
    else          begin en_s = f_en; en_g = '0; end
    push_expected();
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (f_en[i] && ptr[i] < f_len[i] && c >= f_delay[i] &&
            int'($urandom_range(1, 100)) <= valid_pct) begin
          in_valid[i] = 1'b1;
          in_data[i]  = f_key[i][ptr[i]];
          in_aux[i]   = f_aux[i][ptr[i]];
          in_last[i]  = (ptr[i] == f_len[i] - 1);
        end else begin
          in_valid[i] = 1'b0;
          in_data[i]  = $urandom;
          in_aux[i]   = AW'($urandom);
          in_last[i]  = 1'($urandom);
        end
      end
      if (bp_start >= 0 && c >= bp_start && c < bp_start + 5) out_ready = 1'b0;
      else out_ready = (int'($urandom_range(1, 100)) <= ready_pct);
      #1;
      for (int i = 0; i < N; i++)
        if (!f_en[i]) check("in_ready_disabled", 64'(obs_in_ready[i]), 64'(0));
      if (stall_lane >= 0 && ptr[stall_lane] == 0)
        check("strict_stall", 64'(obs_out_valid), 64'(0));
      if (bp_start >= 0 && c == bp_start + 4)
        for (int i = 0; i < N; i++)
          if (in_valid[i]) check("in_ready_backpressure", 64'(obs_in_ready[i]), 64'(0));
      for (int i = 0; i < N; i++)
        if (in_valid[i] && obs_in_ready[i]) ptr[i]++;
      done = (exp_q.size() == 0) && !obs_out_valid;
      for (int i = 0; i < N; i++) if (ptr[i] != f_len[i]) done = 0;
    end
    check("frame_done", 64'(done), 64'(1));
    if (!done) exp_q.delete();
    in_valid  = '0;
    out_ready = 1'b1;
    check("busy_idle", 64'(obs_busy), 64'(0));
  endtask

  // ---------------- monitor ----------------
  logic             p_stall = 1'b0;
  logic [EXP_W-1:0] p_word;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("hold_valid", 64'(obs_out_valid), 64'(1));
        check("hold_stable", 64'(obs_word), 64'(p_word));
      end
      if (obs_out_valid && out_ready) begin
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected none", obs_word);
        end else begin
          check("out_beat", 64'(obs_word), 64'(exp_q.pop_front()));
        end
      end
      p_stall = obs_out_valid && !out_ready;
      p_word  = obs_word;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    sel = 0; en_s = '0; en_g = '0; in_valid = '0; in_last = '0;
    in_data = '0; in_aux = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(s_out_valid), 64'(0));
    check("rst_out_data", 64'(s_out_data), 64'(0));
    check("rst_busy", 64'(s_busy), 64'(0));
    check("rst_g_out_valid", 64'(g_out_valid), 64'(0));
    rst_n = 1'b1;

    // All lanes disabled: nothing accepted, nothing emitted
    in_valid = 4'hF;
    repeat (4) begin
      @(negedge clk); #1;
      check("off_in_ready", 64'(s_in_ready), 64'(0));
      check("off_out_valid", 64'(s_out_valid), 64'(0));
      check("off_busy", 64'(s_busy), 64'(0));
    end
    in_valid = '0;

    // Interleaved sorted merge
    frame_defaults();
    f_len = '{3, 2, 3, 1};
    f_key[0][0] = 1; f_key[0][1] = 5; f_key[0][2] = 9;
    f_key[1][0] = 2; f_key[1][1] = 6;
    f_key[2][0] = 3; f_key[2][1] = 7; f_key[2][2] = 8;
    f_key[3][0] = 4;
    run_frame();

    // Tie on key 7 between lanes 0 and 2
    frame_defaults();
    f_len = '{1, 1, 1, 1};
    f_key[0][0] = 7; f_key[1][0] = 9; f_key[2][0] = 7; f_key[3][0] = 8;
    f_aux[0][0] = 8'hA0; f_aux[2][0] = 8'hC2;
    run_frame();

    // Strict stall behind a silent lane
    frame_defaults();
    f_len = '{1, 1, 1, 1};
    f_key[0][0] = 10; f_key[1][0] = 11; f_key[2][0] = 12; f_key[3][0] = 0;
    f_delay[3] = 8;
    stall_lane = 3;
    run_frame();

    // Back-pressure window mid-frame
    frame_defaults();
    gen_lanes(4);
    f_len = '{4, 4, 4, 4};
    bp_start = 6;
    run_frame();

    // Randomized strict frames
    for (int t = 0; t < 25; t++) begin
      frame_defaults();
      f_en = 4'($urandom_range(1, 15));
      gen_lanes(4);
      for (int i = 0; i < N; i++) f_delay[i] = int'($urandom_range(0, 3));
      valid_pct = int'($urandom_range(40, 100));
      ready_pct = int'($urandom_range(40, 100));
      run_frame();
    end

    // Greedy mode, lanes 0 and 2, lane 0 streams back to back
    frame_defaults();
    f_greedy = 1;
    f_en = 4'b0101;
    f_len = '{3, 0, 1, 0};
    f_key[0][0] = 10; f_key[0][1] = 20; f_key[0][2] = 30;
    f_key[2][0] = 40;
    f_delay[2] = 12;
    hs_cyc_q.delete();
    run_frame();
    check("greedy_beats", 64'(hs_cyc_q.size()), 64'(4));
    if (hs_cyc_q.size() >= 3) begin
      check("greedy_tput_1", 64'(hs_cyc_q[1] - hs_cyc_q[0]), 64'(1));
      check("greedy_tput_2", 64'(hs_cyc_q[2] - hs_cyc_q[1]), 64'(1));
    end

    // Asynchronous reset with a beat pending on the output
    sel = 0; en_g = '0; en_s = 4'hF; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      in_data[i] = W'(5 + i); in_aux[i] = AW'(i); in_last[i] = 1'b0;
    end
    in_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (s_out_valid) break;
    end
    check("pre_reset_valid", 64'(s_out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    in_valid = '0;
    #1;
    check("arst_out_valid", 64'(s_out_valid), 64'(0));
    check("arst_out_data", 64'(s_out_data), 64'(0));
    check("arst_out_index", 64'(s_out_index), 64'(0));
    check("arst_out_aux", 64'(s_out_aux), 64'(0));
    check("arst_out_last", 64'(s_out_last), 64'(0));
    check("arst_busy", 64'(s_busy), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Fresh frame after reset
    frame_defaults();
    gen_lanes(3);
    run_frame();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
